// File: rtl/c7552_addcmp_reg.sv
// rtl/c7552_addcmp_reg.sv - registered 32-bit add/sub, unsigned comparator and byte-parity checker
module c7552_addcmp_reg #(
    parameter int IN_W  = 207,
    parameter int OUT_W = 108
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  in_vec,
    output logic [OUT_W-1:0] out_vec
);

    logic [31:0] a, b, x, y;
    logic        cin;
    logic [3:0]  pa, pb, px, py;
    logic [1:0]  sel;
    logic        cmp_en;
    logic [57:0] misc;
    logic        loop;

    assign a      = in_vec[31:0];
    assign b      = in_vec[63:32];
    assign x      = in_vec[95:64];
    assign y      = in_vec[127:96];
    assign cin    = in_vec[128];
    assign pa     = in_vec[132:129];
    assign pb     = in_vec[136:133];
    assign px     = in_vec[140:137];
    assign py     = in_vec[144:141];
    assign sel    = in_vec[146:145];
    assign cmp_en = in_vec[147];
    assign misc   = in_vec[205:148];
    assign loop   = in_vec[206];

    // Even parity: a byte is in error when its data bits plus its parity bit have odd weight.
    function automatic logic parity_err(input logic [31:0] d, input logic [3:0] p);
        logic e;
        e = 1'b0;
        for (int i = 0; i < 4; i++) begin
            e = e | ((^d[8*i +: 8]) ^ p[i]);
        end
        return e;
    endfunction

    logic [31:0]      opa, opb;
    logic             carry_in;
    logic [32:0]      add_res;
    logic [31:0]      sum;
    logic             cout, ovf;
    logic [3:0]       perr;
    logic [3:0]       byte_xor;
    logic [OUT_W-1:0] nxt;

    always_comb begin
        opa      = a;
        opb      = b;
        carry_in = cin;
        case (sel)
            2'b00: begin opa = a; opb = b;  carry_in = cin;  end
            2'b01: begin opa = a; opb = ~b; carry_in = 1'b1; end
            2'b10: begin opa = x; opb = y;  carry_in = cin;  end
            default: begin opa = a; opb = 32'd0; carry_in = 1'b0; end
        endcase
        add_res = {1'b0, opa} + {1'b0, opb} + {32'd0, carry_in};
        sum     = add_res[31:0];
        cout    = (sel == 2'b11) ? 1'b0 : add_res[32];
        ovf     = (sel == 2'b11) ? 1'b0
                : ((opa[31] == opb[31]) && (sum[31] != opa[31]));

        perr = {parity_err(y, py), parity_err(x, px), parity_err(b, pb), parity_err(a, pa)};

        byte_xor = 4'd0;
        for (int i = 0; i < 4; i++) begin
            byte_xor[i] = ^sum[8*i +: 8];
        end

        nxt          = '0;
        nxt[31:0]    = sum;
        nxt[32]      = cout;
        nxt[33]      = ovf;
        nxt[34]      = (sum == 32'd0);
        nxt[35]      = cmp_en && (x > y);
        nxt[36]      = cmp_en && (x == y);
        nxt[37]      = cmp_en && (x < y);
        nxt[41:38]   = perr;
        nxt[42]      = |perr;
        nxt[43]      = ^sum;
        nxt[101:44]  = misc;
        nxt[105:102] = byte_xor;
        nxt[106]     = sum[31];
        nxt[107]     = loop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vec <= '0;
        end else begin
            out_vec <= nxt;
        end
    end

endmodule

// File: tb/tb_c7552_addcmp_reg.sv
// tb/tb_c7552_addcmp_reg.sv - scoreboard bench for c7552_addcmp_reg against an arithmetic reference model
module tb_c7552_addcmp_reg;

    logic         clk;
    logic         rst;
    logic [206:0] in_vec;
    logic [107:0] out_vec;

    int compared;
    int mismatched;

    logic [107:0] expq[$];
    string        nameq[$];

    c7552_addcmp_reg dut (
        .clk     (clk),
        .rst     (rst),
        .in_vec  (in_vec),
        .out_vec (out_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [206:0] mk(
        input logic [31:0] a, input logic [31:0] b,
        input logic [31:0] x, input logic [31:0] y,
        input logic cin,
        input logic [3:0] pa, input logic [3:0] pb,
        input logic [3:0] px, input logic [3:0] py,
        input logic [1:0] sel, input logic cmp_en,
        input logic [57:0] misc, input logic loop);
        return {loop, misc, cmp_en, sel, py, px, pb, pa, cin, y, x, b, a};
    endfunction

    function automatic logic odd_bytes(input logic [31:0] d, input logic [3:0] p);
        logic e;
        logic [31:0] dd;
        e  = 1'b0;
        dd = d;
        for (int i = 0; i < 4; i++) begin
            if ((($countones(dd[8*i +: 8]) + int'(p[i])) % 2) != 0) e = 1'b1;
        end
        return e;
    endfunction

    // Reference model built from the arithmetic rules with 64-bit integers.
    function automatic logic [107:0] model(input logic [206:0] v);
        logic [31:0] a, b, x, y, sum;
        logic [3:0]  pe, bx;
        logic [1:0]  sel;
        logic        cin, cen, cout, ovf;
        longint      ua, ub, us, sa, sb, sr;
        logic [63:0] us_bits;
        logic [107:0] r;
        a = v[31:0]; b = v[63:32]; x = v[95:64]; y = v[127:96];
        cin = v[128]; sel = v[146:145]; cen = v[147];
        ovf = 1'b0;
        cout = 1'b0;
        sum = a;
        if (sel != 2'b11) begin
            case (sel)
                2'b00: begin ua = longint'(a); ub = longint'(b); sa = longint'($signed(a)); sb = longint'($signed(b)); end
                2'b01: begin ua = longint'(a); ub = 64'hFFFF_FFFF - longint'(b); sa = longint'($signed(a)); sb = -longint'($signed(b)) - 1; end
                default: begin ua = longint'(x); ub = longint'(y); sa = longint'($signed(x)); sb = longint'($signed(y)); end
            endcase
            us = ua + ub + ((sel == 2'b01) ? 1 : longint'(cin));
            sr = sa + sb + ((sel == 2'b01) ? 1 : longint'(cin));
            us_bits = us;
            sum  = us_bits[31:0];
            cout = us_bits[32];
            ovf  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        end
        pe = {odd_bytes(y, v[144:141]), odd_bytes(x, v[140:137]),
              odd_bytes(b, v[136:133]), odd_bytes(a, v[132:129])};
        for (int i = 0; i < 4; i++) bx[i] = ($countones(sum[8*i +: 8]) % 2) != 0;
        r = '0;
        r[31:0]    = sum;
        r[32]      = cout;
        r[33]      = ovf;
        r[34]      = (sum == 0);
        r[35]      = cen && (x > y);
        r[36]      = cen && (x == y);
        r[37]      = cen && (x < y);
        r[41:38]   = pe;
        r[42]      = pe != 0;
        r[43]      = ($countones(sum) % 2) != 0;
        r[101:44]  = v[205:148];
        r[105:102] = bx;
        r[106]     = sum[31];
        r[107]     = v[206];
        return r;
    endfunction

    task automatic drive(input string nm, input logic r, input logic [206:0] v);
        @(negedge clk);
        rst    = r;
        in_vec = v;
        expq.push_back(r ? 108'd0 : model(v));
        nameq.push_back(nm);
    endtask

    task automatic chk_bit(input string nm, input logic act, input logic req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s actual=%0b required=%0b", nm, act, req);
        end
    endtask

    // Monitor: one result emerges after every rising edge that follows a stimulus.
    initial begin
        logic [107:0] e;
        string        nm;
        forever begin
            @(posedge clk);
            #2;
            if (expq.size() != 0) begin
                e  = expq.pop_front();
                nm = nameq.pop_front();
                compared++;
                if (out_vec !== e) begin
                    mismatched++;
                    $display("FAIL %s actual=%h required=%h", nm, out_vec, e);
                end
            end
        end
    end

    logic [57:0]  alt;
    logic [206:0] ones;
    logic [31:0]  ra, rb, rx, ry;

    initial begin
        rst    = 1'b1;
        in_vec = '0;
        for (int i = 0; i < 58; i++) alt[i] = (i % 2) == 1;
        ones = '1;

        drive("reset0", 1'b1, ones);
        drive("reset1", 1'b1, ones);
        drive("release", 1'b0, '0);
        @(posedge clk); #2;
        chk_bit("release_zero", out_vec[34], 1'b1);

        drive("add_wrap",  1'b0, mk(32'hFFFF_FFFF, 32'd1, 0, 0, 1'b0, 4'h0, 4'h1, 0, 0, 2'b00, 1'b0, 0, 1'b0));
        @(posedge clk); #2;
        chk_bit("add_wrap_cout", out_vec[32], 1'b1);
        drive("add_ovf",   1'b0, mk(32'h7FFF_FFFF, 32'd1, 0, 0, 1'b0, 4'h0, 4'h0, 0, 0, 2'b00, 1'b0, 0, 1'b0));
        @(posedge clk); #2;
        chk_bit("add_ovf_bit", out_vec[33], 1'b1);
        chk_bit("add_msb", out_vec[106], 1'b1);
        drive("sub_neg",   1'b0, mk(32'd5, 32'd7, 0, 0, 1'b1, 0, 0, 0, 0, 2'b01, 1'b0, 0, 1'b0));
        @(posedge clk); #2;
        chk_bit("sub_neg_borrow", out_vec[32], 1'b0);
        drive("sub_ovf",   1'b0, mk(32'h8000_0000, 32'd1, 0, 0, 1'b0, 0, 0, 0, 0, 2'b01, 1'b0, 0, 1'b0));
        drive("sub_zero",  1'b0, mk(0, 0, 0, 0, 1'b0, 0, 0, 0, 0, 2'b01, 1'b0, 0, 1'b0));
        drive("cmp_gt",    1'b0, mk(0, 0, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 0, 0, 0, 0, 2'b00, 1'b1, 0, 1'b0));
        @(posedge clk); #2;
        chk_bit("cmp_gt_bit", out_vec[35], 1'b1);
        drive("cmp_off",   1'b0, mk(0, 0, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 0, 0, 0, 0, 2'b00, 1'b0, 0, 1'b0));
        drive("cmp_eq",    1'b0, mk(0, 0, 32'h1234_5678, 32'h1234_5678, 1'b0, 0, 0, 4'hF, 4'hF, 2'b11, 1'b1, 0, 1'b0));
        drive("xy_add",    1'b0, mk(0, 0, 32'd3, 32'd4, 1'b1, 0, 0, 4'h1, 4'h1, 2'b10, 1'b1, 0, 1'b0));
        @(posedge clk); #2;
        chk_bit("xy_add_lt", out_vec[37], 1'b1);
        drive("par_err",   1'b0, mk(32'd1, 0, 0, 0, 1'b0, 4'h0, 4'h0, 0, 0, 2'b00, 1'b0, 0, 1'b0));
        @(posedge clk); #2;
        chk_bit("par_err_a", out_vec[38], 1'b1);
        chk_bit("par_err_any", out_vec[42], 1'b1);
        drive("par_ok",    1'b0, mk(32'd1, 0, 0, 0, 1'b0, 4'h1, 4'h0, 0, 0, 2'b00, 1'b0, 0, 1'b0));
        drive("par_b",     1'b0, mk(0, 32'h0000_FF00, 0, 0, 1'b0, 4'h0, 4'h0, 0, 0, 2'b00, 1'b0, 0, 1'b0));
        drive("misc_loop", 1'b0, mk(0, 0, 0, 0, 1'b0, 0, 0, 0, 0, 2'b00, 1'b0, alt, 1'b1));
        @(posedge clk); #2;
        chk_bit("loop_bit", out_vec[107], 1'b1);
        drive("misc_next", 1'b0, mk(0, 0, 0, 0, 1'b0, 0, 0, 0, 0, 2'b00, 1'b0, ~alt, 1'b0));
        @(posedge clk); #2;
        chk_bit("loop_clear", out_vec[107], 1'b0);
        drive("rst_wins",  1'b1, mk(32'hFFFF_FFFF, 32'd1, 0, 0, 1'b1, 0, 0, 0, 0, 2'b00, 1'b1, alt, 1'b1));

        for (int n = 0; n < 400; n++) begin
            ra = $urandom; rb = $urandom; rx = $urandom; ry = $urandom;
            if ($urandom_range(7) == 0) ry = rx;
            if ($urandom_range(7) == 0) rb = ra;
            drive($sformatf("rand%0d", n), ($urandom_range(15) == 0),
                  mk(ra, rb, rx, ry, 1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                     4'($urandom), 2'($urandom), 1'($urandom),
                     {26'($urandom), 32'($urandom)}, 1'($urandom)));
        end

        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        compared++;
        if (expq.size() != 0) begin
            mismatched++;
            $display("FAIL drain actual=%0d required=0", expq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/c7552_addcmp_reg.md
Name: c7552_addcmp_reg

Overview:
- Registered 32-bit adder/subtractor plus 32-bit unsigned magnitude comparator with byte-parity checking, modelled on the ISCAS-85 c7552 function class.
- Inputs and outputs are flat packed vectors, 207 in and 108 out; bit positions are fixed by this spec.
- Sits as a leaf datapath block in the benchmark/fault-simulation regression; all outputs register once per clock.

Parameters:
- IN_W, 207, input vector width (fixed; other values unsupported)
- OUT_W, 108, output vector width (fixed)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_vec  input  207  packed operand/control vector
- out_vec  output  108  packed registered result vector

Behaviour:
- Clocking and reset:
  - One clock (clk); reset is synchronous and active-high (rst).
  - rst high at a rising edge sets out_vec to all zeros; rst has priority over new data.
  - Latency is exactly 1 cycle. out_vec after edge k is f(in_vec sampled at edge k), with no other state.
  - Releasing rst gives valid results at the first edge with rst low. There is no handshake; a new vector is accepted every cycle.
- Input fields:
  - a = in[31:0]
  - b = in[63:32]
  - x = in[95:64]
  - y = in[127:96]
  - cin = in[128]
  - pa = in[132:129], pb = in[136:133], px = in[140:137], py = in[144:141]: byte-parity bits; bit i covers byte i, byte 0 = bits 7:0
  - sel = in[146:145]
  - cmp_en = in[147]
  - misc = in[205:148] (58 bits)
  - loop = in[206]
- Adder, selected by sel:
  - 00: {cout,sum} = a + b + cin
  - 01: {cout,sum} = a + ~b + 1; cin ignored; cout = 1 means no borrow
  - 10: {cout,sum} = x + y + cin
  - 11: sum = a, cout = 0
  - All arithmetic is 33-bit unsigned with wrap-around; no saturation.
  - ovf = signed two's-complement overflow of the selected add/sub (operand MSBs equal and sum MSB different; for 01 use ~b). ovf = 0 for sel = 11.
  - zero = (sum == 0)
- Comparator, unsigned x vs y:
  - gt/eq/lt is one-hot when cmp_en = 1.
  - All three are 0 when cmp_en = 0.
- Parity (even convention):
  - Error bit for an operand = OR over bytes i of (XOR of byte i XOR parity bit i).
  - perr = {py_err, px_err, pb_err, pa_err}
  - any_err = OR of perr
  - Errors only flag; they never block the adder or comparator.
- Output map:
  - out[31:0] = sum
  - out[32] = cout
  - out[33] = ovf
  - out[34] = zero
  - out[35] = gt, out[36] = eq, out[37] = lt
  - out[41:38] = perr
  - out[42] = any_err
  - out[43] = XOR of all sum bits
  - out[101:44] = misc, direct registered copy in order
  - out[105:102] = per-byte XOR of sum, bit i = byte i
  - out[106] = sum[31]
  - out[107] = loop, registered copy
- Boundaries:
  - Max + 1 wraps with cout = 1.
  - 0 - 0 gives sum 0, cout 1, zero 1.
  - x == y with cmp_en = 1 sets eq only.
  - All parity bits 0 with all-zero operands gives no error.
  - rst and data changing in the same cycle: reset wins.

Test Plan:
- Reset: rst = 1 with in_vec all ones for 2 cycles → out_vec = 0. Release with in_vec = 0 → next out_vec = 0 except out[34] = 1 (zero) and out[37:35] = 0.
- Add: sel = 00, a = 0xFFFFFFFF, b = 1, cin = 0 → sum 0, cout 1, zero 1, ovf 0, out[43] = 0. Then a = 0x7FFFFFFF, b = 1 → sum 0x80000000, ovf 1, out[106] = 1.
- Subtract: sel = 01, a = 5, b = 7, cin = 1 → sum 0xFFFFFFFE, cout 0, ovf 0. Then a = 0x80000000, b = 1 → ovf 1, cout 1.
- Compare: cmp_en = 1, x = 0x80000000, y = 0x7FFFFFFF → gt = 1, eq = 0, lt = 0. Same values with cmp_en = 0 → all three 0. sel = 10, x = 3, y = 4, cin = 1 → sum 8.
- Parity: a = 0x00000001, pa = 0000 → out[38] = 1, out[42] = 1. Same a with pa = 0001 → out[38] = 0. b = 0x0000FF00, pb = 0 → out[39] = 0.
- Passthrough and latency: misc = alternating 1010…, loop = 1 on one cycle only → out[101:44] and out[107] match exactly one cycle later, then return to their new values the following cycle.
